// File: rtl/video_crop.sv
// Video crop: de-derived pixel counters gate de/data to a configurable window.
// Window updates are double-buffered and committed on the vsync rising edge.
module video_crop #(
    parameter int DATA_WIDTH = 24,
    parameter int X_WIDTH    = 12,
    parameter int Y_WIDTH    = 12,
    parameter int H_DISP     = 1920,
    parameter int V_DISP     = 1080
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [X_WIDTH-1:0]    cfg_start_x,
    input  logic [Y_WIDTH-1:0]    cfg_start_y,
    input  logic [X_WIDTH-1:0]    cfg_end_x,
    input  logic [Y_WIDTH-1:0]    cfg_end_y,
    input  logic                  cfg_valid,
    input  logic                  bypass,
    input  logic                  vs_i,
    input  logic                  hs_i,
    input  logic                  de_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  vs_o,
    output logic                  hs_o,
    output logic                  de_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  cfg_applied,
    output logic                  cfg_err
);

    typedef enum logic {WAIT_VS, ACTIVE} state_t;

    typedef struct packed {
        logic [X_WIDTH-1:0] sx;
        logic [Y_WIDTH-1:0] sy;
        logic [X_WIDTH-1:0] ex;
        logic [Y_WIDTH-1:0] ey;
    } win_t;

    localparam win_t FULL_WIN = '{sx: '0, sy: '0, ex: X_WIDTH'(H_DISP), ey: Y_WIDTH'(V_DISP)};
    localparam logic [X_WIDTH-1:0] X_MAX = '1;
    localparam logic [Y_WIDTH-1:0] Y_MAX = '1;

    state_t                r_state;
    logic                  r_vs_prev;
    logic                  r_de_prev;
    logic [X_WIDTH-1:0]    r_px;
    logic [Y_WIDTH-1:0]    r_py;
    win_t                  r_active;
    win_t                  r_pending;
    logic                  r_pend_flag;
    logic                  r_vs_o;
    logic                  r_hs_o;
    logic                  r_de_o;
    logic [DATA_WIDTH-1:0] r_data_o;
    logic                  r_cfg_applied;
    logic                  r_cfg_err;

    win_t w_cfg;
    logic w_cfg_ok;
    logic w_vs_rise;
    logic w_de_fall;
    logic w_in_win;
    logic w_de_next;

    assign w_cfg     = '{sx: cfg_start_x, sy: cfg_start_y, ex: cfg_end_x, ey: cfg_end_y};
    assign w_cfg_ok  = cfg_valid && (cfg_end_x > cfg_start_x) && (cfg_end_y > cfg_start_y);
    assign w_vs_rise = vs_i && !r_vs_prev;
    assign w_de_fall = r_de_prev && !de_i;
    assign w_in_win  = (r_px >= r_active.sx) && (r_px < r_active.ex) &&
                       (r_py >= r_active.sy) && (r_py < r_active.ey);
    assign w_de_next = (r_state == ACTIVE) && de_i && (bypass || w_in_win);

    // r_vs_prev resets high so a vsync already asserted at reset release is not taken as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_prev <= 1'b1;
            r_de_prev <= 1'b0;
            r_px      <= '0;
            r_py      <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            r_vs_prev <= vs_i;
            r_de_prev <= de_i;
            if (w_vs_rise) begin
                r_px <= '0;
                r_py <= '0;
            end else begin
                if (w_de_fall)
                    r_px <= '0;
                else if (de_i && r_px != X_MAX)
                    r_px <= r_px + X_WIDTH'(1);
                if (w_de_fall && r_py != Y_MAX)
                    r_py <= r_py + Y_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active      <= FULL_WIN;
            r_pending     <= FULL_WIN;
            r_pend_flag   <= 1'b0;
            r_cfg_applied <= 1'b0;
            r_cfg_err     <= 1'b0;
        end else begin
            if (w_cfg_ok)
                r_pending <= w_cfg;
            if (cfg_valid)
                r_cfg_err <= !w_cfg_ok;
            if (w_vs_rise) begin
                // A valid strobe on the edge itself bypasses the pending stage.
                if (w_cfg_ok)
                    r_active <= w_cfg;
                else if (r_pend_flag)
                    r_active <= r_pending;
                r_pend_flag   <= 1'b0;
                r_cfg_applied <= r_pend_flag || w_cfg_ok;
            end else begin
                r_cfg_applied <= 1'b0;
                if (w_cfg_ok)
                    r_pend_flag <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= WAIT_VS;
            r_vs_o   <= 1'b0;
            r_hs_o   <= 1'b0;
            r_de_o   <= 1'b0;
            r_data_o <= '0;
        end else begin
            if (r_state == WAIT_VS && w_vs_rise)
                r_state <= ACTIVE;
            r_vs_o   <= vs_i;
            r_hs_o   <= hs_i;
            r_de_o   <= w_de_next;
            r_data_o <= w_de_next ? data_i : '0;
        end
    end

    assign vs_o        = r_vs_o;
    assign hs_o        = r_hs_o;
    assign de_o        = r_de_o;
    assign data_o      = r_data_o;
    assign cfg_applied = r_cfg_applied;
    assign cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_video_crop.sv
// Bench for video_crop: a window-level model driven by the frame generator's own
// pixel coordinates, table-driven crop scenarios, corner sequences and random frames.
module tb_video_crop;

    localparam int DW = 24;
    localparam int XW = 12;
    localparam int YW = 12;
    localparam int HD = 16;
    localparam int VD = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [XW-1:0] cfg_start_x, cfg_end_x;
    logic [YW-1:0] cfg_start_y, cfg_end_y;
    logic          cfg_valid, bypass, vs_i, hs_i, de_i;
    logic [DW-1:0] data_i;
    logic          vs_o, hs_o, de_o, cfg_applied, cfg_err;
    logic [DW-1:0] data_o;

    always #5 clk = ~clk;

    video_crop #(.DATA_WIDTH(DW), .X_WIDTH(XW), .Y_WIDTH(YW), .H_DISP(HD), .V_DISP(VD)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_start_x(cfg_start_x), .cfg_start_y(cfg_start_y),
        .cfg_end_x(cfg_end_x), .cfg_end_y(cfg_end_y),
        .cfg_valid(cfg_valid), .bypass(bypass),
        .vs_i(vs_i), .hs_i(hs_i), .de_i(de_i), .data_i(data_i),
        .vs_o(vs_o), .hs_o(hs_o), .de_o(de_o), .data_o(data_o),
        .cfg_applied(cfg_applied), .cfg_err(cfg_err)
    );

    typedef struct { int sx; int sy; int ex; int ey; } win_t;
    typedef struct { win_t w; bit err; int cur; int cnt; logic [DW-1:0] first; } vec_t;

    // Reference model: window sets, pending flag, sticky error, started flag.
    win_t m_act, m_pend;
    bit   m_pflag, m_err, m_started, m_prev_vs;
    bit   rnd_ev = 1'b0;

    int            n_vec = 0;
    int            n_err = 0;
    int            out_cnt = 0;
    logic [DW-1:0] out_first = '0;

    localparam win_t NO_WIN = '{0, 0, 0, 0};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({vs_o, hs_o, de_o, cfg_applied, cfg_err, data_o});
    endfunction

    task automatic model_reset();
        m_act     = '{0, 0, HD, VD};
        m_pend    = '{0, 0, HD, VD};
        m_pflag   = 1'b0;
        m_err     = 1'b0;
        m_started = 1'b0;
        m_prev_vs = 1'b1;
    endtask

    task automatic set_strobe(input win_t w);
        cfg_start_x = XW'(w.sx);
        cfg_start_y = YW'(w.sy);
        cfg_end_x   = XW'(w.ex);
        cfg_end_y   = YW'(w.ey);
        cfg_valid   = 1'b1;
    endtask

    task automatic rand_strobe();
        win_t w;
        w.sx = int'($urandom_range(0, 18));
        w.sy = int'($urandom_range(0, 9));
        w.ex = int'($urandom_range(0, 24));
        w.ey = int'($urandom_range(0, 12));
        set_strobe(w);
    endtask

    // One clock: inputs already driven at the falling edge; (x,y) is the generator's pixel position.
    task automatic step(input int x, input int y);
        logic [28:0] expv;
        bit rise, inw, valid, ede, eapp;
        win_t cw;
        int xs;
        if (rnd_ev) begin
            if ($urandom_range(0, 39) == 0) rand_strobe();
            if ($urandom_range(0, 59) == 0) bypass = ~bypass;
        end
        if (rst_n !== 1'b1) begin
            model_reset();
            expv = '0;
        end else begin
            cw    = '{int'(cfg_start_x), int'(cfg_start_y), int'(cfg_end_x), int'(cfg_end_y)};
            rise  = vs_i && !m_prev_vs;
            xs    = (x > 4095) ? 4095 : x;
            inw   = xs >= m_act.sx && xs < m_act.ex && y >= m_act.sy && y < m_act.ey;
            ede   = m_started && de_i && (bypass || inw);
            valid = cfg_valid && cw.ex > cw.sx && cw.ey > cw.sy;
            eapp  = rise && (m_pflag || valid);
            if (cfg_valid) m_err = !valid;
            if (rise) begin
                if (valid) m_act = cw;
                else if (m_pflag) m_act = m_pend;
                m_pflag   = 1'b0;
                m_started = 1'b1;
            end else if (valid) begin
                m_pflag = 1'b1;
            end
            if (valid) m_pend = cw;
            m_prev_vs = vs_i;
            expv = {vs_i, hs_i, ede, eapp, m_err, ede ? data_i : {DW{1'b0}}};
        end
        @(negedge clk);
        check("outputs", outs(), 64'(expv));
        if (de_o) begin
            out_cnt++;
            if (out_cnt == 1) out_first = data_o;
        end
        cfg_valid = 1'b0;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", outs(), 64'(0));
        model_reset();
        step(0, 0);
        step(0, 0);
        rst_n = 1'b1;
    endtask

    // One frame: vsync, then h lines of w active pixels separated by blanking.
    task automatic drive_frame(input int w, input int h, input bit rnd_data, input int strobe_line,
                               input win_t sw, input bit strobe_at_vs, input int rst_line);
        out_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            vs_i = 1'b1; hs_i = 1'b0; de_i = 1'b0;
            if (i == 0 && strobe_at_vs) set_strobe(sw);
            if (i == 0 && rnd_ev && $urandom_range(0, 3) == 0) rand_strobe();
            step(0, 0);
        end
        vs_i = 1'b0;
        for (int y = 0; y < h; y++) begin
            for (int c = 0; c < 3; c++) begin
                hs_i = (c < 2); de_i = 1'b0;
                if (c == 0 && y == strobe_line) set_strobe(sw);
                step(0, y);
            end
            hs_i = 1'b0;
            for (int x = 0; x < w; x++) begin
                de_i   = 1'b1;
                data_i = rnd_data ? DW'($urandom) : {12'(y), 12'(x)};
                if (y == rst_line && x == w / 2) reset_pulse();
                step(x, y);
            end
            de_i = 1'b0;
        end
        step(0, 0);
        step(0, 0);
    endtask

    vec_t tbl[7];

    initial begin
        tbl[0] = '{'{2, 1, 6, 4},     1'b0, 128, 12,  24'h001002};
        tbl[1] = '{'{5, 1, 5, 4},     1'b1, 12,  12,  24'h001002};
        tbl[2] = '{'{0, 0, 16, 8},    1'b0, 12,  128, 24'h000000};
        tbl[3] = '{'{10, 5, 30, 20},  1'b0, 128, 18,  24'h00500A};
        tbl[4] = '{'{3, 3, 4, 4},     1'b0, 18,  1,   24'h003003};
        tbl[5] = '{'{0, 7, 16, 0},    1'b1, 1,   1,   24'h003003};
        tbl[6] = '{'{14, 0, 16, 8},   1'b0, 1,   16,  24'h00000E};

        rst_n = 1'b0; cfg_valid = 1'b0; bypass = 1'b0;
        vs_i = 1'b0; hs_i = 1'b0; de_i = 1'b0; data_i = '0;
        cfg_start_x = '0; cfg_start_y = '0; cfg_end_x = '0; cfg_end_y = '0;
        model_reset();
        @(negedge clk);
        step(0, 0);
        check("reset_state", outs(), 64'(0));

        // Start-up: vsync high across reset release mid-line, de pulses before any real vsync edge.
        vs_i = 1'b1; hs_i = 1'b1; de_i = 1'b1; data_i = 24'hABCDEF;
        step(5, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(6 + i, 0);
        vs_i = 1'b0;
        for (int i = 0; i < 5; i++) step(9 + i, 0);
        de_i = 1'b0; hs_i = 1'b0;
        step(0, 0);
        out_cnt = 0;
        de_i = 1'b1;
        for (int i = 0; i < 4; i++) step(i, 1);
        de_i = 1'b0;
        step(0, 0);
        check("startup_no_de", 64'(out_cnt), 64'(0));

        // Default window equals the whole 16x8 frame.
        drive_frame(HD, VD, 1'b0, -1, NO_WIN, 1'b0, -1);
        check("default_cnt", 64'(out_cnt), 64'(128));
        check("default_first", 64'(out_first), 64'(0));

        foreach (tbl[i]) begin
            drive_frame(HD, VD, 1'b0, 2, tbl[i].w, 1'b0, -1);
            check("tbl_cur_cnt", 64'(out_cnt), 64'(tbl[i].cur));
            check("tbl_err", 64'(cfg_err), 64'(tbl[i].err));
            drive_frame(HD, VD, 1'b0, -1, NO_WIN, 1'b0, -1);
            check("tbl_cnt", 64'(out_cnt), 64'(tbl[i].cnt));
            check("tbl_first", 64'(out_first), 64'(tbl[i].first));
        end

        // Valid strobe on the vsync rising edge takes effect in that same frame.
        drive_frame(HD, VD, 1'b0, -1, '{0, 0, 8, 2}, 1'b1, -1);
        check("simul_cnt", 64'(out_cnt), 64'(16));
        check("simul_first", 64'(out_first), 64'(0));

        // Mid-frame reset on row 3, then full window restored, then bypass.
        drive_frame(HD, VD, 1'b0, -1, NO_WIN, 1'b0, 3);
        drive_frame(HD, VD, 1'b0, 5, '{4, 4, 6, 6}, 1'b0, -1);
        check("post_reset_full", 64'(out_cnt), 64'(128));
        bypass = 1'b1;
        drive_frame(HD, VD, 1'b0, -1, NO_WIN, 1'b0, -1);
        check("bypass_cnt", 64'(out_cnt), 64'(128));
        bypass = 1'b0;
        drive_frame(HD, VD, 1'b0, -1, NO_WIN, 1'b0, -1);
        check("unbypass_cnt", 64'(out_cnt), 64'(4));

        // Column counter saturates at all-ones on an over-long line.
        drive_frame(4, 2, 1'b1, 0, '{0, 0, 4095, 8}, 1'b0, -1);
        drive_frame(4100, 1, 1'b1, -1, NO_WIN, 1'b0, -1);
        check("sat_cnt", 64'(out_cnt), 64'(4095));

        // Random frame geometry, data, strobes and bypass toggles.
        rnd_ev = 1'b1;
        for (int f = 0; f < 30; f++)
            drive_frame(int'($urandom_range(1, 20)), int'($urandom_range(1, 10)), 1'b1, -1, NO_WIN, 1'b0, -1);
        rnd_ev = 1'b0;
        bypass = 1'b0;
        step(0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
